// File: rtl/reg_bank_fwd_pkg.sv
// Shared definitions for the ID/EX operand register bank with forwarding.
package reg_bank_fwd_pkg;

    // Default widths
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;

    // Forwarding source code reported on fwd_a / fwd_b
    typedef enum logic [1:0] {
        FWD_FILE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_src_t;

endpackage

// File: rtl/reg_bank_fwd_fwd_select.sv
// Combinational operand resolver: picks the newest in-flight value for one
// source register, priority EX > MEM > WB > register file.
module fwd_select
    import reg_bank_fwd_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int R0_ZERO = 1
) (
    input  logic [ADDR_W-1:0] src,
    input  logic              match_ex,
    input  logic              match_mem,
    input  logic              match_wb,
    input  logic [DATA_W-1:0] file_val,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] value,
    output fwd_src_t          code
);

    // Priority select of the operand value and its source code
    always_comb begin
        value = file_val;
        code  = FWD_FILE;
        if ((R0_ZERO != 0) && (src == '0)) begin
            value = '0;
            code  = FWD_FILE;
        end else if (match_ex) begin
            value = ex_data;
            code  = FWD_EX;
        end else if (match_mem) begin
            value = mem_data;
            code  = FWD_MEM;
        end else if (match_wb) begin
            value = wb_data;
            code  = FWD_WB;
        end
    end

endmodule

// File: rtl/reg_bank_fwd.sv
// ID/EX register bank: register file with one write port, two forwarded
// read operands registered into A/B, and load-use hazard detection.
module reg_bank_fwd
    import reg_bank_fwd_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int R0_ZERO  = 1,
    parameter int INIT_IDX = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stall_in,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              op_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use_stall
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    logic              zero_a, zero_b;
    logic              m_ex_a, m_mem_a, m_wb_a;
    logic              m_ex_b, m_mem_b, m_wb_b;
    logic [DATA_W-1:0] val_a, val_b;
    fwd_src_t          code_a, code_b;

    // Stage-destination matches; register 0 never matches when hardwired
    always_comb begin
        zero_a  = (R0_ZERO != 0) && (rs_a == '0);
        zero_b  = (R0_ZERO != 0) && (rs_b == '0);
        m_ex_a  = ex_wr_en  && (ex_rd  == rs_a) && !zero_a;
        m_mem_a = mem_wr_en && (mem_rd == rs_a) && !zero_a;
        m_wb_a  = wb_wr_en  && (wb_rd  == rs_a) && !zero_a;
        m_ex_b  = ex_wr_en  && (ex_rd  == rs_b) && !zero_b;
        m_mem_b = mem_wr_en && (mem_rd == rs_b) && !zero_b;
        m_wb_b  = wb_wr_en  && (wb_rd  == rs_b) && !zero_b;
    end

    // A load in EX cannot forward yet; hold ID for one cycle
    always_comb begin
        load_use_stall = id_valid && ex_wr_en && ex_is_load &&
                         (m_ex_a || (!imm_sel && m_ex_b));
    end

    fwd_select #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO)
    ) u_sel_a (
        .src       (rs_a),
        .match_ex  (m_ex_a),
        .match_mem (m_mem_a),
        .match_wb  (m_wb_a),
        .file_val  (regs[rs_a]),
        .ex_data   (ex_data),
        .mem_data  (mem_data),
        .wb_data   (wb_data),
        .value     (val_a),
        .code      (code_a)
    );

    fwd_select #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO)
    ) u_sel_b (
        .src       (rs_b),
        .match_ex  (m_ex_b),
        .match_mem (m_mem_b),
        .match_wb  (m_wb_b),
        .file_val  (regs[rs_b]),
        .ex_data   (ex_data),
        .mem_data  (mem_data),
        .wb_data   (wb_data),
        .value     (val_b),
        .code      (code_b)
    );

    // Register file write port; independent of any stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
            end
        end else if (wb_wr_en && !((R0_ZERO != 0) && (wb_rd == '0))) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Operand registers: freeze on stall_in, bubble on load-use, else load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A        <= '0;
            B        <= '0;
            op_valid <= 1'b0;
            fwd_a    <= FWD_FILE;
            fwd_b    <= FWD_FILE;
        end else if (stall_in) begin
            A        <= A;
            B        <= B;
            op_valid <= op_valid;
            fwd_a    <= fwd_a;
            fwd_b    <= fwd_b;
        end else if (load_use_stall) begin
            op_valid <= 1'b0;
        end else begin
            A        <= val_a;
            B        <= imm_sel ? imm : val_b;
            fwd_a    <= code_a;
            fwd_b    <= imm_sel ? FWD_FILE : code_b;
            op_valid <= id_valid;
        end
    end

endmodule

// File: tb/tb_reg_bank_fwd.sv
// Directed testbench for reg_bank_fwd with default parameters.
module tb_reg_bank_fwd;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] rs_a, rs_b;
    logic [7:0] imm;
    logic       imm_sel;
    logic       ex_wr_en, ex_is_load;
    logic [4:0] ex_rd;
    logic [7:0] ex_data;
    logic       mem_wr_en;
    logic [4:0] mem_rd;
    logic [7:0] mem_data;
    logic       wb_wr_en;
    logic [4:0] wb_rd;
    logic [7:0] wb_data;
    logic       stall_in;
    logic [7:0] A, B;
    logic       op_valid;
    logic [1:0] fwd_a, fwd_b;
    logic       load_use_stall;

    int checks   = 0;
    int failures = 0;

    reg_bank_fwd #(
        .DATA_W   (8),
        .ADDR_W   (5),
        .R0_ZERO  (1),
        .INIT_IDX (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .rs_a           (rs_a),
        .rs_b           (rs_b),
        .imm            (imm),
        .imm_sel        (imm_sel),
        .ex_wr_en       (ex_wr_en),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .ex_data        (ex_data),
        .mem_wr_en      (mem_wr_en),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .wb_wr_en       (wb_wr_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .stall_in       (stall_in),
        .A              (A),
        .B              (B),
        .op_valid       (op_valid),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .load_use_stall (load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writers();
        ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
        mem_wr_en = 0; mem_rd = 0; mem_data = 0;
        wb_wr_en = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        reset = 0; id_valid = 0; rs_a = 0; rs_b = 0; imm = 0; imm_sel = 0;
        stall_in = 0;
        clear_writers();
        #3;
        checks++; if (A !== 8'h00) begin failures++; $display("FAIL reset_A got %h want 00", A); end
        checks++; if (B !== 8'h00) begin failures++; $display("FAIL reset_B got %h want 00", B); end
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0) begin failures++; $display("FAIL reset_fwd got %b/%b want 0/0", fwd_a, fwd_b); end
        step();
        reset = 1;
    endtask

    task automatic test_file_read();
        rs_a = 3; rs_b = 7; id_valid = 1;
        step();
        checks++; if (A !== 8'd3) begin failures++; $display("FAIL file_A got %h want 03", A); end
        checks++; if (B !== 8'd7) begin failures++; $display("FAIL file_B got %h want 07", B); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0) begin failures++; $display("FAIL file_fwd got %b/%b want 0/0", fwd_a, fwd_b); end
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL file_op_valid got %b want 1", op_valid); end
    endtask

    task automatic test_ex_mem_priority();
        ex_wr_en = 1; ex_rd = 3; ex_data = 8'hAA;
        mem_wr_en = 1; mem_rd = 3; mem_data = 8'h55;
        rs_a = 3; rs_b = 7;
        step();
        checks++; if (A !== 8'hAA) begin failures++; $display("FAIL ex_fwd_A got %h want aa", A); end
        checks++; if (fwd_a !== 2'd1) begin failures++; $display("FAIL ex_fwd_code got %0d want 1", fwd_a); end
        checks++; if (B !== 8'd7) begin failures++; $display("FAIL ex_fwd_B got %h want 07", B); end
        ex_wr_en = 0;
        step();
        checks++; if (A !== 8'h55) begin failures++; $display("FAIL mem_fwd_A got %h want 55", A); end
        checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL mem_fwd_code got %0d want 2", fwd_a); end
        clear_writers();
    endtask

    task automatic test_wb_bypass();
        wb_wr_en = 1; wb_rd = 9; wb_data = 8'h3C; rs_b = 9; rs_a = 1;
        step();
        checks++; if (B !== 8'h3C) begin failures++; $display("FAIL wb_fwd_B got %h want 3c", B); end
        checks++; if (fwd_b !== 2'd3) begin failures++; $display("FAIL wb_fwd_code got %0d want 3", fwd_b); end
        wb_wr_en = 0;
        step();
        checks++; if (B !== 8'h3C) begin failures++; $display("FAIL wb_written_B got %h want 3c", B); end
        checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL wb_written_code got %0d want 0", fwd_b); end
        clear_writers();
    endtask

    task automatic test_load_use();
        // Load targeting only rs_b while imm is selected: no hazard
        ex_is_load = 1; ex_wr_en = 1; ex_rd = 6; rs_a = 2; rs_b = 6; imm_sel = 1; imm = 8'h21;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_imm_masked got %b want 0", load_use_stall); end
        imm_sel = 0;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_rs_b got %b want 1", load_use_stall); end
        ex_rd = 4; rs_a = 4; rs_b = 7; id_valid = 1;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_detect got %b want 1", load_use_stall); end
        step();
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got %b want 0", op_valid); end
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_rd = 4; mem_data = 8'h77;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_clear got %b want 0", load_use_stall); end
        step();
        checks++; if (A !== 8'h77) begin failures++; $display("FAIL lu_mem_A got %h want 77", A); end
        checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL lu_mem_code got %0d want 2", fwd_a); end
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL lu_op_valid got %b want 1", op_valid); end
        clear_writers();
    endtask

    task automatic test_r0();
        wb_wr_en = 1; wb_rd = 0; wb_data = 8'hFF;
        ex_wr_en = 1; ex_rd = 0; ex_data = 8'hE1;
        rs_a = 0; rs_b = 0; imm_sel = 1; imm = 8'h12;
        step();
        checks++; if (A !== 8'h00) begin failures++; $display("FAIL r0_A got %h want 00", A); end
        checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL r0_code got %0d want 0", fwd_a); end
        checks++; if (B !== 8'h12) begin failures++; $display("FAIL r0_imm_B got %h want 12", B); end
        checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL r0_imm_code got %0d want 0", fwd_b); end
        clear_writers();
        ex_is_load = 1; ex_wr_en = 1; ex_rd = 0; imm_sel = 0;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL r0_no_stall got %b want 0", load_use_stall); end
        clear_writers();
        step();
        checks++; if ({A, B} !== 16'h0000) begin failures++; $display("FAIL r0_file got %h/%h want 00/00", A, B); end
    endtask

    task automatic test_id_valid_zero();
        id_valid = 0; rs_a = 1; rs_b = 2;
        step();
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL idv0_op_valid got %b want 0", op_valid); end
        id_valid = 1;
        step();
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL idv1_op_valid got %b want 1", op_valid); end
    endtask

    task automatic test_stall_and_reset();
        rs_a = 1; rs_b = 2; id_valid = 1;
        step();
        checks++; if ({A, B} !== 16'h0102) begin failures++; $display("FAIL pre_stall got %h/%h want 01/02", A, B); end
        stall_in = 1; wb_wr_en = 1; wb_rd = 5; wb_data = 8'h66; rs_a = 5; rs_b = 5; id_valid = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({A, B, op_valid} !== {8'h01, 8'h02, 1'b1}) begin
                failures++; $display("FAIL stall_hold%0d got %h/%h/%b want 01/02/1", i, A, B, op_valid);
            end
        end
        stall_in = 0; wb_wr_en = 0; id_valid = 1;
        step();
        checks++; if (A !== 8'h66) begin failures++; $display("FAIL post_stall_A got %h want 66", A); end
        checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL post_stall_code got %0d want 0", fwd_a); end
        stall_in = 1;
        #2;
        reset = 0;
        #1;
        checks++; if ({A, B, op_valid, fwd_a, fwd_b} !== 21'd0) begin
            failures++; $display("FAIL async_reset got %h/%h/%b/%0d/%0d want all 0", A, B, op_valid, fwd_a, fwd_b);
        end
        step();
        reset = 1; stall_in = 0;
        step();
        checks++; if (A !== 8'h05) begin failures++; $display("FAIL reg5_reinit got %h want 05", A); end
    endtask

    initial begin
        test_reset();
        test_file_read();
        test_ex_mem_priority();
        test_wb_bypass();
        test_load_use();
        test_r0();
        test_id_valid_zero();
        test_stall_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
